// File: rtl/stream_accumulator_if.sv
// Stream accumulator bus: operand stream in, adder side-channel, packet result out.
interface stream_accumulator_if #(
    parameter int N     = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;

    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic [N-1:0]     add_sum;
    logic             add_carry;

    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic [CNT_W-1:0] out_carries;
    logic [CNT_W-1:0] out_count;

    // Environment side: produces beats, hosts the adder, consumes results.
    modport master (
        output in_valid, in_data, in_last, add_sum, add_carry, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_sum, out_carries, out_count
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, in_last, add_sum, add_carry, out_ready,
        output in_ready, add_a, add_b, out_valid, out_sum, out_carries, out_count
    );
endinterface

// File: rtl/stream_accumulator.sv
// Packet accumulator front end for an external combinational ripple-carry adder.
// Sums a valid/ready operand stream per packet, counting beats and carry-outs,
// then holds the result on a valid/ready output until it is taken.
module stream_accumulator #(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_accumulator_if.slave  bus
);

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     acc_q;
    logic [N-1:0]     acc_d;
    logic [CNT_W-1:0] carries_q;
    logic [CNT_W-1:0] carries_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             accept;
    logic             transfer;

    // Adder operands and result port come straight from the registers.
    assign bus.add_a       = acc_q;
    assign bus.add_b       = bus.in_data;
    assign bus.out_sum     = acc_q;
    assign bus.out_carries = carries_q;
    assign bus.out_count   = count_q;

    // Next-state and handshake decode; counters saturate until the packet clears.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        carries_d    = carries_q;
        count_d      = count_q;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        accept       = 1'b0;
        transfer     = 1'b0;

        case (state_q)
            ACC: begin
                bus.in_ready = ~rst;
                accept       = bus.in_valid & ~rst;
                if (accept) begin
                    acc_d = bus.add_sum;
                    if (bus.add_carry && (carries_q != CNT_MAX))
                        carries_d = carries_q + CNT_W'(1);
                    if (count_q != CNT_MAX)
                        count_d = count_q + CNT_W'(1);
                    if (bus.in_last)
                        state_d = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                transfer      = bus.out_ready;
                if (transfer) begin
                    acc_d     = '0;
                    carries_d = '0;
                    count_d   = '0;
                    state_d   = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    // State and datapath registers with synchronous reset discarding any packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACC;
            acc_q     <= '0;
            carries_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carries_q <= carries_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_stream_accumulator.sv
// Self-checking bench for stream_accumulator: table of per-cycle vectors on a
// CNT_W=8 instance plus a saturation sequence on a CNT_W=4 instance.
module tb_stream_accumulator;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    stream_accumulator_if #(.N(16), .CNT_W(8)) bus8 ();
    stream_accumulator_if #(.N(16), .CNT_W(4)) bus4 ();

    stream_accumulator #(.N(16), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    stream_accumulator #(.N(16), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // Behavioural stand-ins for the external combinational adders.
    assign {bus8.add_carry, bus8.add_sum} = {1'b0, bus8.add_a} + {1'b0, bus8.add_b};
    assign {bus4.add_carry, bus4.add_sum} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b};

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] data;
        logic        last;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_sum;
        logic [7:0]  e_car;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic iv, input logic [15:0] d,
                           input logic l, input logic o, input logic e_rdy,
                           input logic e_ov, input logic [15:0] e_sum,
                           input logic [7:0] e_car, input logic [7:0] e_cnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.data = d; v.last = l; v.ordy = o;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sum = e_sum;
        v.e_car = e_car; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s step=%0d got=0x%0h want=0x%0h", name, idx, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst           = v.rst;
        bus8.in_valid = v.iv;
        bus8.in_data  = v.data;
        bus8.in_last  = v.last;
        bus8.out_ready = v.ordy;
    endtask

    task automatic drive4(input logic iv, input logic [15:0] d, input logic l, input logic o);
        bus4.in_valid  = iv;
        bus4.in_data   = d;
        bus4.in_last   = l;
        bus4.out_ready = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_last = 1'b0; bus8.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.in_last = 1'b0; bus4.out_ready = 1'b0;

        //      rst iv data     last ordy | rdy ov sum      car cnt
        // Reset, including a beat offered while reset is high.
        add_vec(1, 0, 16'h0000, 0, 0,     0, 0, 16'h0000, 0, 0);
        add_vec(1, 1, 16'h0005, 1, 0,     0, 0, 16'h0000, 0, 0);
        add_vec(0, 0, 16'h0000, 0, 0,     1, 0, 16'h0000, 0, 0);
        // Packet 1,2,3 with out_ready high throughout.
        add_vec(0, 1, 16'd1,    0, 1,     1, 0, 16'd1,    0, 1);
        add_vec(0, 1, 16'd2,    0, 1,     1, 0, 16'd3,    0, 2);
        add_vec(0, 1, 16'd3,    1, 1,     0, 1, 16'd6,    0, 3);
        add_vec(0, 0, 16'd0,    0, 1,     1, 0, 16'd0,    0, 0);
        // Wrap-around packet, then five cycles of backpressure with beats offered.
        add_vec(0, 1, 16'hFFFF, 0, 0,     1, 0, 16'hFFFF, 0, 1);
        add_vec(0, 1, 16'h0002, 1, 0,     0, 1, 16'h0001, 1, 2);
        for (int i = 0; i < 5; i++)
            add_vec(0, 1, 16'h0100, 0, 0, 0, 1, 16'h0001, 1, 2);
        add_vec(0, 1, 16'h0100, 0, 1,     1, 0, 16'h0000, 0, 0);
        add_vec(0, 1, 16'h0100, 1, 0,     0, 1, 16'h0100, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 1,     1, 0, 16'h0000, 0, 0);
        // Single-beat packet.
        add_vec(0, 1, 16'h1234, 1, 0,     0, 1, 16'h1234, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 1,     1, 0, 16'h0000, 0, 0);
        // Four beats with a three-cycle gap and a one-cycle gap.
        add_vec(0, 1, 16'd10,   0, 0,     1, 0, 16'd10,   0, 1);
        for (int i = 0; i < 3; i++)
            add_vec(0, 0, 16'hAAAA, 0, 0, 1, 0, 16'd10,   0, 1);
        add_vec(0, 1, 16'd20,   0, 0,     1, 0, 16'd30,   0, 2);
        add_vec(0, 1, 16'd30,   0, 0,     1, 0, 16'd60,   0, 3);
        add_vec(0, 0, 16'd99,   1, 0,     1, 0, 16'd60,   0, 3);
        add_vec(0, 1, 16'd40,   1, 0,     0, 1, 16'd100,  0, 4);
        add_vec(0, 0, 16'd0,    0, 0,     0, 1, 16'd100,  0, 4);
        add_vec(0, 0, 16'd0,    0, 1,     1, 0, 16'd0,    0, 0);
        // Reset after two beats, then packet 5,7.
        add_vec(0, 1, 16'd9,    0, 0,     1, 0, 16'd9,    0, 1);
        add_vec(0, 1, 16'hFFF8, 0, 0,     1, 0, 16'h0001, 1, 2);
        add_vec(1, 1, 16'd5,    1, 1,     0, 0, 16'd0,    0, 0);
        add_vec(0, 1, 16'd5,    0, 0,     1, 0, 16'd5,    0, 1);
        add_vec(0, 1, 16'd7,    1, 0,     0, 1, 16'd12,   0, 2);
        add_vec(0, 0, 16'd0,    0, 1,     1, 0, 16'd0,    0, 0);
        // Reset while a result is pending.
        add_vec(0, 1, 16'd3,    1, 0,     0, 1, 16'd3,    0, 1);
        add_vec(1, 0, 16'd0,    0, 0,     0, 0, 16'd0,    0, 0);
        add_vec(0, 0, 16'd0,    0, 0,     1, 0, 16'd0,    0, 0);

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            @(posedge clk);
            #1;
            check_output("in_ready",    i, 32'(bus8.in_ready),    32'(vecs[i].e_rdy));
            check_output("out_valid",   i, 32'(bus8.out_valid),   32'(vecs[i].e_ov));
            check_output("out_sum",     i, 32'(bus8.out_sum),     32'(vecs[i].e_sum));
            check_output("out_carries", i, 32'(bus8.out_carries), 32'(vecs[i].e_car));
            check_output("out_count",   i, 32'(bus8.out_count),   32'(vecs[i].e_cnt));
        end

        // CNT_W=4: twenty beats of 0xFFFF saturate both counters.
        for (int b = 1; b <= 20; b++) begin
            drive4(1'b1, 16'hFFFF, (b == 20), 1'b0);
            if (b == 3) begin
                check_output("sat_carries_b3", b, 32'(bus4.out_carries), 32'd2);
                check_output("sat_count_b3",   b, 32'(bus4.out_count),   32'd3);
            end
            if (b == 17) begin
                check_output("sat_carries_b17", b, 32'(bus4.out_carries), 32'd15);
                check_output("sat_count_b17",   b, 32'(bus4.out_count),   32'd15);
            end
        end
        check_output("sat_out_valid", 20, 32'(bus4.out_valid),   32'd1);
        check_output("sat_out_sum",   20, 32'(bus4.out_sum),     32'hFFEC);
        check_output("sat_carries",   20, 32'(bus4.out_carries), 32'd15);
        check_output("sat_count",     20, 32'(bus4.out_count),   32'd15);
        drive4(1'b0, 16'h0000, 1'b0, 1'b1);
        check_output("sat_clear_valid", 21, 32'(bus4.out_valid),   32'd0);
        check_output("sat_clear_count", 21, 32'(bus4.out_count),   32'd0);
        check_output("sat_clear_car",   21, 32'(bus4.out_carries), 32'd0);
        check_output("sat_clear_ready", 21, 32'(bus4.in_ready),    32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
